vga_timing_counter: RTL and testbench

Upstream stage of the VGA output path. Divides the system clock down to a pixel-rate tick and runs the horizontal and vertical position counters that the VGA sync/DE decoder consumes. Also produces line and frame strobes and a wrapping frame counter. Supports run/freeze control and a synchronous resync.

---
 rtl/vga_timing_counter.sv | 150 +++++++++++++++
 tb/tb_vga_timing_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_counter.sv
// Pixel-rate prescaler plus horizontal/vertical position counters for the VGA output path.
// Optional sticky vertical-blank flag enabled by defining VGA_VBLANK_IRQ_EN.
module vga_timing_counter #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int V_VISIBLE   = 480,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   resync,
  input  logic                   irq_ack,
  output logic                   pixel_tick,
  output logic [9:0]             h_counter,
  output logic [9:0]             v_counter,
  output logic                   line_end,
  output logic                   frame_end,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   vblank_irq
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic                   advance;
  logic                   tick;
  logic                   h_wrap;
  logic                   v_wrap;
  logic [9:0]             h_count_reg;
  logic [9:0]             h_count_next;
  logic [9:0]             v_count_reg;
  logic [9:0]             v_count_next;
  logic [FRAME_CNT_W-1:0] frame_count_reg;
  logic [FRAME_CNT_W-1:0] frame_count_next;

  // resync suppresses every strobe in its cycle, so it is folded into the tick itself
  assign advance = en && !resync;

  generate
    if (CLK_DIV == 1) begin : g_no_div
      assign tick = advance;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_cnt_reg;
      logic [DIV_W-1:0] div_cnt_next;

      always_comb begin
        div_cnt_next = div_cnt_reg;
        if (resync) begin
          div_cnt_next = '0;
        end else if (en) begin
          div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt_reg <= '0;
        end else begin
          div_cnt_reg <= div_cnt_next;
        end
      end

      assign tick = advance && (div_cnt_reg == DIV_LAST);
    end
  endgenerate

  assign h_wrap     = (h_count_reg == H_LAST);
  assign v_wrap     = (v_count_reg == V_LAST);
  assign pixel_tick = tick;
  assign line_end   = tick && h_wrap;
  assign frame_end  = line_end && v_wrap;

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (resync) begin
      h_count_next = '0;
      v_count_next = '0;
    end else if (tick) begin
      h_count_next = h_wrap ? 10'd0 : h_count_reg + 10'd1;
      if (h_wrap) begin
        v_count_next = v_wrap ? 10'd0 : v_count_reg + 10'd1;
      end
    end
  end

  // frame_end is already zero under resync or freeze, so no extra qualification here
  always_comb begin
    frame_count_next = frame_count_reg;
    if (frame_end) begin
      frame_count_next = frame_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      frame_count_reg <= '0;
    end else begin
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign h_counter   = h_count_reg;
  assign v_counter   = v_count_reg;
  assign frame_count = frame_count_reg;

`ifdef VGA_VBLANK_IRQ_EN
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);

  logic vblank_set;
  logic vblank_irq_reg;
  logic vblank_irq_next;

  // Set when the line wrap lands on the first non-visible line; set beats ack.
  assign vblank_set = line_end && (v_count_next == V_VIS);

  always_comb begin
    vblank_irq_next = vblank_irq_reg;
    if (vblank_set) begin
      vblank_irq_next = 1'b1;
    end else if (irq_ack) begin
      vblank_irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_irq_reg <= 1'b0;
    end else begin
      vblank_irq_reg <= vblank_irq_next;
    end
  end

  assign vblank_irq = vblank_irq_reg;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = &{1'b0, irq_ack, 10'(V_VISIBLE)};
  assign vblank_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter with a linear-pixel-count reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_vga_timing_counter;

  localparam int DIV = 4;
  localparam int H   = 8;
  localparam int V   = 5;
  localparam int VV  = 3;
  localparam int FW  = 8;
`ifdef VGA_VBLANK_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          resync = 1'b0;
  logic          irq_ack = 1'b0;
  logic          pixel_tick;
  logic [9:0]    h_counter;
  logic [9:0]    v_counter;
  logic          line_end;
  logic          frame_end;
  logic [FW-1:0] frame_count;
  logic          vblank_irq;

  int checks = 0;
  int failures = 0;

  vga_timing_counter #(
    .CLK_DIV(DIV), .H_TOTAL(H), .V_TOTAL(V), .V_VISIBLE(VV), .FRAME_CNT_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .resync(resync), .irq_ack(irq_ack),
    .pixel_tick(pixel_tick), .h_counter(h_counter), .v_counter(v_counter),
    .line_end(line_end), .frame_end(frame_end), .frame_count(frame_count),
    .vblank_irq(vblank_irq)
  );

  always #5 clk = ~clk;

  // Model: enabled clocks since last restart; position is plain division of that count.
  longint ecnt = 0;
  int     frames = 0;
  bit     irq_m = 1'b0;

  function automatic int m_pos();
    return int'((ecnt / DIV) % (H * V));
  endfunction
  function automatic int m_h();
    return m_pos() % H;
  endfunction
  function automatic int m_v();
    return m_pos() / H;
  endfunction
  function automatic bit m_tick();
    return en && !resync && ((ecnt % DIV) == DIV - 1);
  endfunction
  function automatic bit m_le();
    return m_tick() && (m_h() == H - 1);
  endfunction
  function automatic bit m_fe();
    return m_le() && (m_v() == V - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tk;
    bit fe;
    bit set;
    if (!rst_n) begin
      ecnt   = 0;
      frames = 0;
      irq_m  = 1'b0;
    end else begin
      tk  = m_tick();
      fe  = m_fe();
      set = 1'b0;
      if (tk && (((ecnt / DIV) + 1) % (H * V)) == VV * H) set = 1'b1;
      if (resync) begin
        ecnt = 0;
      end else if (en) begin
        if (fe) frames = frames + 1;
        ecnt = ecnt + 1;
      end
      if (IRQ_ON != 0) begin
        if (set) irq_m = 1'b1;
        else if (irq_ack) irq_m = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_pixel_tick", pixel_tick, m_tick());
    chk("cyc_h_counter", h_counter, m_h());
    chk("cyc_v_counter", v_counter, m_v());
    chk("cyc_line_end", line_end, m_le());
    chk("cyc_frame_end", frame_end, m_fe());
    chk("cyc_frame_count", frame_count, frames % (1 << FW));
    chk("cyc_vblank_irq", vblank_irq, irq_m);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Advance until a pixel tick is pending at position (h, v); bounded.
  task automatic seek(input int h, input int v);
    int k;
    for (k = 0; k < 4 * H * V * DIV; k++) begin
      if (m_tick() && m_h() == h && m_v() == v) break;
      step(1);
    end
    if (k == 4 * H * V * DIV) begin
      checks++;
      failures++;
      $display("FAIL seek_timeout actual=none required=h%0d_v%0d", h, v);
    end
  endtask

  int fc_saved;

  initial begin
    step(3);
    chk("rst_h", h_counter, 0);
    chk("rst_v", v_counter, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_tick", pixel_tick, 0);
    chk("rst_irq", vblank_irq, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    step(3);
    chk("first_tick", pixel_tick, 1);
    chk("first_tick_h", h_counter, 0);
    step(1);
    chk("after_tick_h", h_counter, 1);
    chk("after_tick_v", v_counter, 0);
    chk("after_tick_pt", pixel_tick, 0);

    seek(H - 1, 0);
    chk("line_end_hi", line_end, 1);
    chk("line_no_fe", frame_end, 0);
    step(1);
    chk("line_wrap_h", h_counter, 0);
    chk("line_wrap_v", v_counter, 1);
    chk("line_end_lo", line_end, 0);

    seek(H - 1, V - 1);
    chk("frame_end_hi", frame_end, 1);
    chk("frame_end_le", line_end, 1);
    chk("frame_fc_before", frame_count, 0);
    step(1);
    chk("frame_wrap_h", h_counter, 0);
    chk("frame_wrap_v", v_counter, 0);
    chk("frame_fc_after", frame_count, 1);

    // Flag set during the first frame; clear it, then exercise set-beats-ack.
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("irq_cleared", vblank_irq, 0);
    seek(H - 1, VV - 1);
    irq_ack = 1'b1;
    step(1);
    chk("irq_set_wins", vblank_irq, IRQ_ON);
    chk("irq_pos_v", v_counter, VV);
    step(1);
    irq_ack = 1'b0;
    chk("irq_ack_clear", vblank_irq, 0);

    seek(5, 1);
    step(3);
    chk("frz_pre_h", h_counter, 6);
    fc_saved = int'(frame_count);
    en = 1'b0;
    step(20);
    chk("frz_h", h_counter, 6);
    chk("frz_v", v_counter, 1);
    chk("frz_fc", frame_count, fc_saved);
    chk("frz_tick", pixel_tick, 0);
    en = 1'b1;
    step(1);
    chk("frz_resume_tick", pixel_tick, 1);
    chk("frz_resume_h", h_counter, 6);

    seek(H - 1, V - 1);
    fc_saved = int'(frame_count);
    resync = 1'b1;
    #1;
    chk("rs_no_fe", frame_end, 0);
    chk("rs_no_le", line_end, 0);
    chk("rs_no_tick", pixel_tick, 0);
    step(1);
    resync = 1'b0;
    chk("rs_h", h_counter, 0);
    chk("rs_v", v_counter, 0);
    chk("rs_fc", frame_count, fc_saved);
    step(3);
    chk("rs_next_tick", pixel_tick, 1);
    step(1);
    chk("rs_next_h", h_counter, 1);

    // 256 whole frames from a restart bring frame_count back to its start value.
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    fc_saved = int'(frame_count);
    step(256 * H * V * DIV);
    chk("wrap_fc", frame_count, fc_saved);
    chk("wrap_h", h_counter, 0);
    chk("wrap_v", v_counter, 0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
